// File: rtl/regfile_wr_demux8_pkg.sv
// rtl/regfile_wr_demux8_pkg.sv - shared sizes and constants for the register-bank write path
package regfile_wr_demux8_pkg;

  localparam int DW_DEFAULT = 16;
  localparam int NREG       = 8;
  localparam int SELW       = 3;

  localparam logic [NREG-1:0] STROBE_NONE = 8'h00;

  typedef logic [SELW-1:0] sel_t;

endpackage

// File: rtl/regfile_wr_demux8_if.sv
// rtl/regfile_wr_demux8_if.sv - write handshake bundle into the register bank
interface regfile_wr_demux8_if
  import regfile_wr_demux8_pkg::*;
#(
  parameter int DW = DW_DEFAULT
);

  logic          wr_valid;
  logic          wr_ready;
  sel_t          wr_sel;
  logic [DW-1:0] wr_data;

  modport master (
    output wr_valid,
    output wr_sel,
    output wr_data,
    input  wr_ready
  );

  modport slave (
    input  wr_valid,
    input  wr_sel,
    input  wr_data,
    output wr_ready
  );

endinterface

// File: rtl/regfile_wr_demux8_dec3to8.sv
// rtl/regfile_wr_demux8_dec3to8.sv - combinational 3-to-8 one-hot decoder with enable
module dec3to8
  import regfile_wr_demux8_pkg::*;
(
  input  logic            en,
  input  sel_t            sel,
  output logic [NREG-1:0] onehot
);

  always_comb begin
    onehot = STROBE_NONE;
    if (en) begin
      onehot[sel] = 1'b1;
    end
  end

endmodule

// File: rtl/regfile_wr_demux8.sv
// rtl/regfile_wr_demux8.sv - 8x16 register bank with single-entry staged write, decoded commit and bypassed reads
module regfile_wr_demux8
  import regfile_wr_demux8_pkg::*;
#(
  parameter int DW      = DW_DEFAULT,
  parameter bit R0_ZERO = 1'b0
) (
  input  logic                clk,
  input  logic                rst_n,
  regfile_wr_demux8_if.slave  wr,
  input  logic                commit_stall,
  output logic [NREG-1:0]     wr_strobe,
  output logic                pend,
  input  sel_t                rd_sel_a,
  output logic [DW-1:0]       rd_data_a,
  input  sel_t                rd_sel_b,
  output logic [DW-1:0]       rd_data_b
);

  logic [DW-1:0]   regs [NREG];
  sel_t            buf_sel;
  logic [DW-1:0]   buf_data;
  logic            accept;
  logic            commit;
  logic            commit_hits_r0;
  logic [NREG-1:0] commit_onehot;

  // The buffer drains and refills on the same edge, so a stall only blocks when it is full.
  assign wr.wr_ready      = ~pend | ~commit_stall;
  assign accept           = wr.wr_valid & wr.wr_ready;
  assign commit           = pend & ~commit_stall;
  assign commit_hits_r0   = R0_ZERO && (buf_sel == '0);

  dec3to8 u_commit_dec (
    .en     (commit),
    .sel    (buf_sel),
    .onehot (commit_onehot)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend      <= 1'b0;
      buf_sel   <= '0;
      buf_data  <= '0;
      wr_strobe <= STROBE_NONE;
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
    end else begin
      wr_strobe <= commit_onehot;
      if (commit && !commit_hits_r0) begin
        regs[buf_sel] <= buf_data;
      end
      if (accept) begin
        pend     <= 1'b1;
        buf_sel  <= wr.wr_sel;
        buf_data <= wr.wr_data;
      end else if (commit) begin
        pend <= 1'b0;
      end
    end
  end

  sel_t          rd_sel  [2];
  logic [DW-1:0] rd_data [2];

  assign rd_sel[0] = rd_sel_a;
  assign rd_sel[1] = rd_sel_b;
  assign rd_data_a = rd_data[0];
  assign rd_data_b = rd_data[1];

  // Hard-wired zero takes priority over the bypass so a staged write to r0 never leaks out.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rd_data[p] = regs[rd_sel[p]];
      if (R0_ZERO && (rd_sel[p] == '0)) begin
        rd_data[p] = '0;
      end else if (pend && (rd_sel[p] == buf_sel)) begin
        rd_data[p] = buf_data;
      end
    end
  end

endmodule
